// File: rtl/fp_unpack_pipe.sv
// fp_unpack_pipe
//   Pipelined IEEE-754 unpack/classify unit for arbitrary exponent and
//   fraction widths. Each accepted word is decoded combinationally on entry
//   to slot 0 and the decoded fields ride through STAGES register slots.
//   Each slot carries its own valid bit, and ready ripples back
//   combinationally, so bubbles collapse and full throughput is one word
//   per cycle.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   in_valid     in_bits holds a word to unpack
//   in_ready     unit accepts in_bits this cycle
//   in_bits      packed word {sign, exponent, fraction}
//   out_valid    output fields hold a result
//   out_ready    consumer takes the result this cycle
//   out_sign     sign bit
//   out_exp_raw  biased exponent field, unmodified
//   out_exp_unb  signed unbiased exponent (EXP_W+2 bits, two's complement)
//   out_sig      {hidden bit, fraction}
//   out_class    one-hot: [0] zero [1] subnormal [2] normal [3] inf
//                [4] qnan [5] snan

module fp_unpack_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_bits,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic [EXP_W-1:0]       out_exp_raw,
  output logic [EXP_W+1:0]       out_exp_unb,
  output logic [MAN_W:0]         out_sig,
  output logic [5:0]             out_class
);

  // Bit positions inside the one-hot class vector.
  typedef enum int unsigned {
    CLS_ZERO = 0,
    CLS_SUB  = 1,
    CLS_NORM = 2,
    CLS_INF  = 3,
    CLS_QNAN = 4,
    CLS_SNAN = 5
  } cls_idx_e;

  typedef struct packed {
    logic               sign;
    logic [EXP_W-1:0]   exp_raw;
    logic [EXP_W+1:0]   exp_unb;
    logic [MAN_W:0]     sig;
    logic [5:0]         cls;
  } slot_t;

  // BIAS = 2^(EXP_W-1)-1 built as a bit pattern so it is exact for any width.
  localparam logic [EXP_W+1:0] BIAS = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [EXP_W+1:0] ONE  = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic [EXP_W+1:0] EMIN = ONE - BIAS;   // zero / subnormal
  localparam logic [EXP_W+1:0] ESPC = BIAS + ONE;   // inf / NaN

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_frac;
  logic             w_e_zero;
  logic             w_e_ones;
  logic             w_f_zero;
  slot_t            w_dec;

  logic [STAGES-1:0] w_load;

  logic [STAGES-1:0] r_vld;
  slot_t             r_slot [STAGES];

  // Field extraction and classification.
  assign w_exp    = in_bits[EXP_W+MAN_W-1:MAN_W];
  assign w_frac   = in_bits[MAN_W-1:0];
  assign w_e_zero = (w_exp == '0);
  assign w_e_ones = (w_exp == '1);
  assign w_f_zero = (w_frac == '0);

  always_comb begin
    w_dec         = '0;
    w_dec.sign    = in_bits[EXP_W+MAN_W];
    w_dec.exp_raw = w_exp;
    if (w_e_zero) begin
      w_dec.exp_unb = EMIN;
      w_dec.sig     = {1'b0, w_frac};
      if (w_f_zero) begin
        w_dec.cls[CLS_ZERO] = 1'b1;
      end else begin
        w_dec.cls[CLS_SUB] = 1'b1;
      end
    end else if (w_e_ones) begin
      w_dec.exp_unb = ESPC;
      w_dec.sig     = {1'b1, w_frac};
      if (w_f_zero) begin
        w_dec.cls[CLS_INF] = 1'b1;
      end else if (w_frac[MAN_W-1]) begin
        w_dec.cls[CLS_QNAN] = 1'b1;
      end else begin
        w_dec.cls[CLS_SNAN] = 1'b1;
      end
    end else begin
      w_dec.exp_unb = {2'b00, w_exp} - BIAS;
      w_dec.sig     = {1'b1, w_frac};
      w_dec.cls[CLS_NORM] = 1'b1;
    end
  end

  // Ready ripples from the output back toward slot 0: a slot may load when
  // it is empty or when whatever sits downstream of it can take its word.
  always_comb begin
    logic w_down;
    w_load = '0;
    w_down = out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      w_load[STAGES-1-i] = !r_vld[STAGES-1-i] || w_down;
      w_down             = w_load[STAGES-1-i];
    end
  end

  assign in_ready = !rst && w_load[0];

  // Data only moves when a valid word moves, so held outputs stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_vld[0] <= in_valid;
        if (in_valid) begin
          r_slot[0] <= w_dec;
        end
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (w_load[i]) begin
          r_vld[i] <= r_vld[i-1];
          if (r_vld[i-1]) begin
            r_slot[i] <= r_slot[i-1];
          end
        end
      end
    end
  end

  assign out_valid   = r_vld[STAGES-1];
  assign out_sign    = r_slot[STAGES-1].sign;
  assign out_exp_raw = r_slot[STAGES-1].exp_raw;
  assign out_exp_unb = r_slot[STAGES-1].exp_unb;
  assign out_sig     = r_slot[STAGES-1].sig;
  assign out_class   = r_slot[STAGES-1].cls;

endmodule
